// File: rtl/octaver_multi.sv
// Multi-voice octaver: hysteretic zero-crossing tracker drives /2 and /4 phase flips,
// plus a full-wave "octave up"; enabled voices are mixed at 1/4 gain over a 2-stage pipeline.
module octaver_multi #(
  parameter int W      = 32,
  parameter int HYST   = 16,
  parameter int EN_BIT = 2
) (
  input  logic                clk_48,
  input  logic                rst_n,
  input  logic signed [W-1:0] x,
  input  logic        [3:0]   options,
  input  logic        [3:0]   en,
  output logic signed [W-1:0] y
);

  typedef enum logic {NEG = 1'b0, POS = 1'b1} trk_t;

  localparam logic signed [W-1:0] HYST_P = W'(HYST);
  localparam logic signed [W-1:0] HYST_N = -HYST_P;
  localparam logic signed [W-1:0] MIN_S  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_S  = {1'b0, {(W-1){1'b1}}};

  trk_t                trk, trk_nxt;
  logic                rise;
  logic                div2, div4;
  logic signed [W-1:0] x_r;
  logic        [3:0]   opt_r;
  logic                act_r;
  logic signed [W-1:0] neg_s, down1, down2, up, sum, y_nxt;

  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
    return (v == MIN_S) ? MAX_S : -v;
  endfunction

  // Tracker state register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_48) begin
    if (!rst_n) trk <= NEG;
    else        trk <= trk_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    trk_nxt = trk;
    case (trk)
      NEG: if (x > HYST_P) trk_nxt = POS;
      POS: if (x < HYST_N) trk_nxt = NEG;
      default: trk_nxt = NEG;
    endcase
  end

  always_comb begin
    rise = (trk == NEG) && (trk_nxt == POS);
  end

  // Dividers free-run on every rising crossing so enabling a voice never jumps phase.
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      div2 <= 1'b0;
      div4 <= 1'b0;
    end else if (rise) begin
      div2 <= ~div2;
      if (!div2) div4 <= ~div4;
    end
  end

  // Stage 1: align options and effect select with the sample they arrive with.
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      x_r   <= '0;
      opt_r <= '0;
      act_r <= 1'b0;
    end else begin
      x_r   <= x;
      opt_r <= options;
      act_r <= en[EN_BIT];
    end
  end

  // Stage 2 mix. Four quarter-scaled terms cannot leave the W-bit range, so a
  // wrapping W-bit sum equals the W+2-bit sum truncated back to W bits.
  always_comb begin
    neg_s = neg_sat(x_r);
    down1 = div2 ? x_r : neg_s;
    down2 = div4 ? x_r : neg_s;
    up    = x_r[W-1] ? neg_s : x_r;
    sum   = '0;
    if (opt_r[3]) sum = sum + (down1 >>> 2);
    if (opt_r[2]) sum = sum + (up >>> 2);
    if (opt_r[1]) sum = sum + (down2 >>> 2);
    if (opt_r[0]) sum = sum + (x_r >>> 2);
    y_nxt = (!act_r || opt_r == 4'b0000) ? x_r : sum;
  end

  always_ff @(posedge clk_48) begin
    if (!rst_n) y <= '0;
    else        y <= y_nxt;
  end

endmodule

// File: tb/tb_octaver_multi.sv
// Self-checking bench for octaver_multi: directed scenarios plus randomized traffic,
// compared against a sample-by-sample arithmetic model of the octaver.
module tb_octaver_multi;

  localparam int W      = 32;
  localparam int HYST   = 16;
  localparam int EN_BIT = 2;
  localparam longint MINV = -longint'(64'sd2147483648);
  localparam longint MAXV = 64'sd2147483647;

  logic                clk_48 = 1'b0;
  logic                rst_n;
  logic signed [W-1:0] x;
  logic        [3:0]   options;
  logic        [3:0]   en;
  logic signed [W-1:0] y;

  int total = 0;
  int bad   = 0;

  // Reference model state: tracker polarity, dividers, and the one sample in flight.
  bit         m_pos, m_d2, m_d4;
  logic [W-1:0] m_pend, m_y;

  octaver_multi #(.W(W), .HYST(HYST), .EN_BIT(EN_BIT)) dut (
    .clk_48 (clk_48),
    .rst_n  (rst_n),
    .x      (x),
    .options(options),
    .en     (en),
    .y      (y)
  );

  always #5 clk_48 = ~clk_48;

  function automatic logic [W-1:0] ref_out(input longint s, input logic [3:0] o,
                                           input bit act, input bit d2, input bit d4);
    longint n, sum;
    if (!act || o == 4'b0000) return s[W-1:0];
    n   = (s == MINV) ? MAXV : -s;
    sum = 0;
    if (o[3]) sum += (d2 ? s : n) >>> 2;
    if (o[2]) sum += ((s < 0) ? n : s) >>> 2;
    if (o[1]) sum += (d4 ? s : n) >>> 2;
    if (o[0]) sum += s >>> 2;
    return sum[W-1:0];
  endfunction

  // One clock: the model consumes the same inputs the DUT samples; outputs are read 1 ns later.
  task automatic tick();
    longint s;
    @(posedge clk_48);
    if (!rst_n) begin
      m_y = '0; m_pend = '0; m_pos = 1'b0; m_d2 = 1'b0; m_d4 = 1'b0;
    end else begin
      m_y = m_pend;
      s   = longint'(x);
      if (!m_pos && s > HYST) begin
        m_pos = 1'b1;
        m_d2  = !m_d2;
        if (m_d2) m_d4 = !m_d4;
      end else if (m_pos && s < -HYST) begin
        m_pos = 1'b0;
      end
      m_pend = ref_out(s, options, en[EN_BIT], m_d2, m_d4);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x = 1000; en = 4'b0000; options = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (y !== 0) begin bad++; $display("FAIL reset_hold cyc=%0d y=%0d want 0", i, y); end
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (y !== 0) begin bad++; $display("FAIL reset_first_edge y=%0d want 0", y); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (y !== 1000) begin bad++; $display("FAIL reset_release cyc=%0d y=%0d want 1000", i, y); end
    end
  endtask

  task automatic test_bypass();
    en = 4'b0000;
    for (int i = 1; i <= 20; i++) begin
      x = i; options = 4'($urandom);
      tick();
      if (i >= 2) begin
        total++;
        if (y !== i - 1) begin bad++; $display("FAIL bypass i=%0d y=%0d want %0d", i, y, i - 1); end
      end
    end
  endtask

  task automatic test_down1();
    en = 4'b0100; options = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      x = ((i / 4) % 2 == 0) ? 1000 : -1000;
      tick();
      total++;
      if (y !== m_y) begin bad++; $display("FAIL down1_model i=%0d y=%0d want %0d", i, y, $signed(m_y)); end
      if (i >= 3) begin
        total++;
        if (y !== 250 && y !== -250) begin bad++; $display("FAIL down1_level i=%0d y=%0d want +/-250", i, y); end
      end
    end
  endtask

  task automatic test_up_sat();
    en = 4'b0100; options = 4'b0100;
    x = -1000; tick(); tick();
    total++;
    if (y !== 250) begin bad++; $display("FAIL up_neg y=%0d want 250", y); end
    x = 32'sh8000_0000; tick(); tick();
    total++;
    if (y !== 32'sh1FFF_FFFF) begin bad++; $display("FAIL up_sat y=%h want 1fffffff", y); end
  endtask

  task automatic test_hyst();
    int  seq [8] = '{16, -16, 5, -10, 16, -16, 5, -10};
    bit  d2_fix;
    logic [W-1:0] exp_v;
    en = 4'b0100; options = 4'b1000;
    x = 1000; tick(); tick();
    d2_fix = m_d2;
    foreach (seq[k]) begin
      x = seq[k]; tick(); tick();
      exp_v = ref_out(longint'(seq[k]), 4'b1000, 1'b1, d2_fix, 1'b0);
      total++;
      if (y !== exp_v) begin bad++; $display("FAIL hyst_hold x=%0d y=%0d want %0d", seq[k], y, $signed(exp_v)); end
    end
    x = -17; tick(); tick();
    exp_v = ref_out(-17, 4'b1000, 1'b1, d2_fix, 1'b0);
    total++;
    if (y !== exp_v) begin bad++; $display("FAIL hyst_neg y=%0d want %0d", y, $signed(exp_v)); end
    x = 17; tick(); tick();
    exp_v = ref_out(17, 4'b1000, 1'b1, !d2_fix, 1'b0);
    total++;
    if (y !== exp_v) begin bad++; $display("FAIL hyst_toggle y=%0d want %0d", y, $signed(exp_v)); end
  endtask

  task automatic test_mix();
    bit found;
    en = 4'b0100; options = 4'b1111;
    for (int pass = 0; pass < 2; pass++) begin
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
        x = -1000; tick();
        x = 1000;  tick();
        found = (pass == 0) ? (m_d2 && m_d4) : (!m_d2 && m_d4);
      end
      tick();
      total++;
      if (!found) begin
        bad++; $display("FAIL mix_phase pass=%0d divider phase not reached", pass);
      end else if (y !== ((pass == 0) ? 1000 : 500)) begin
        bad++; $display("FAIL mix_sum pass=%0d y=%0d want %0d", pass, y, (pass == 0) ? 1000 : 500);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      case ($urandom_range(0, 9))
        0:       x = 32'sh8000_0000;
        1, 2:    x = $urandom;
        default: x = $signed($urandom_range(0, 80)) - 40;
      endcase
      options = 4'($urandom);
      en      = 4'($urandom);
      tick();
      total++;
      if (y !== m_y) begin
        bad++; $display("FAIL random i=%0d y=%h want %h", i, y, m_y);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_down1();
    test_up_sat();
    test_hyst();
    test_mix();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
